// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and channel state encoding for tick_gen_multi
package tick_gen_pkg;
  localparam int CNT_W_DEF          = 28;
  localparam int DEFAULT_PERIOD_DEF = 10000000;
  typedef enum logic [1:0] {IDLE, RUN, DONE} ch_state_e;
endpackage

// File: rtl/tick_gen_ch.sv
// tick_gen_ch: one tick channel (FSM, counter, shadow/active period, registered tick/level/done)
//   i_clock/i_reset_n : clock, synchronous active-low reset
//   i_en, i_oneshot   : run enable, one-shot mode
//   i_wr, i_wdata     : period write strobe (already decoded for this channel) and value
//   i_sync_clr        : phase-align clear (only with TICK_GEN_PHASE_SYNC_EN)
//   o_tick, o_level, o_done : boundary pulse, square wave, one-shot halted
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W          = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(DEFAULT_PERIOD_DEF)
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic             i_oneshot,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wdata,
`ifdef TICK_GEN_PHASE_SYNC_EN
  input  logic             i_sync_clr,
`endif
  output logic             o_tick,
  output logic             o_level,
  output logic             o_done
);
  ch_state_e        r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt, r_period, w_period, r_shadow, w_shadow, w_next_p;
  logic             r_tick, w_tick, r_level, w_level, r_done, w_done, w_tc;

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_period = r_period;
    w_shadow = i_wr ? i_wdata : r_shadow;
    // a write landing on the terminal count wins over the older shadow value
    w_next_p = w_shadow;
    w_tick   = 1'b0;
    w_level  = r_level;
    w_done   = r_done;
    w_tc     = r_cnt == r_period - CNT_W'(1);
    case (r_state)
      IDLE: begin
        w_cnt    = '0;
        w_period = w_shadow;
        w_state  = (i_en && w_period != '0) ? RUN : IDLE;
      end
      RUN: begin
        if (!i_en) begin
          w_state = IDLE;
          w_cnt   = '0;
        end
`ifdef TICK_GEN_PHASE_SYNC_EN
        else if (i_sync_clr) begin
          w_cnt   = '0;
          w_level = 1'b0;
        end
`endif
        else if (w_tc) begin
          w_cnt    = '0;
          w_tick   = 1'b1;
          w_level  = ~r_level;
          w_period = w_next_p;
          w_done   = i_oneshot;
          w_state  = i_oneshot ? DONE : (w_next_p == '0 ? IDLE : RUN);
        end
        else w_cnt = r_cnt + CNT_W'(1);
      end
      DONE: begin
        w_period = w_shadow;
        w_state  = (!i_en || i_wr) ? IDLE : DONE;
        w_done   = i_en && !i_wr;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_period <= DEFAULT_PERIOD;
      r_shadow <= DEFAULT_PERIOD;
      r_tick   <= 1'b0;
      r_level  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_period <= w_period;
      r_shadow <= w_shadow;
      r_tick   <= w_tick;
      r_level  <= w_level;
      r_done   <= w_done;
    end
  end

  assign o_tick  = r_tick;
  assign o_level = r_level;
  assign o_done  = r_done;
endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: multi-channel programmable tick generator (periodic / one-shot)
//   i_clock/i_reset_n : clock, synchronous active-low reset
//   i_enable, i_oneshot : per-channel run enable and mode
//   i_period_wr/i_period_sel/i_period_data : period write port (out-of-range select ignored)
//   i_sync_clr : phase-align all running channels, present with TICK_GEN_PHASE_SYNC_EN
//   o_tick, o_level, o_done : per-channel registered outputs
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = CNT_W_DEF,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_DEF
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic [NUM_CH-1:0]         i_enable,
  input  logic [NUM_CH-1:0]         i_oneshot,
  input  logic                      i_period_wr,
  input  logic [$clog2(NUM_CH)-1:0] i_period_sel,
  input  logic [CNT_W-1:0]          i_period_data,
`ifdef TICK_GEN_PHASE_SYNC_EN
  input  logic                      i_sync_clr,
`endif
  output logic [NUM_CH-1:0]         o_tick,
  output logic [NUM_CH-1:0]         o_level,
  output logic [NUM_CH-1:0]         o_done
);
  localparam int SEL_W = $clog2(NUM_CH);
  logic [NUM_CH-1:0] w_wr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr[i] = i_period_wr && i_period_sel == SEL_W'(i);
    tick_gen_ch #(
      .CNT_W         (CNT_W),
      .DEFAULT_PERIOD(CNT_W'(DEFAULT_PERIOD))
    ) u_ch (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_en      (i_enable[i]),
      .i_oneshot (i_oneshot[i]),
      .i_wr      (w_wr[i]),
      .i_wdata   (i_period_data),
`ifdef TICK_GEN_PHASE_SYNC_EN
      .i_sync_clr(i_sync_clr),
`endif
      .o_tick    (o_tick[i]),
      .o_level   (o_level[i]),
      .o_done    (o_done[i])
    );
  end
endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed self-checking bench for tick_gen_multi
module tb_tick_gen_multi;
  localparam int N = 3;
  localparam int W = 28;
  logic         clock = 1'b0;
  logic         reset_n;
  logic [N-1:0] enable, oneshot, tick, level, done;
  logic         period_wr;
  logic [1:0]   period_sel;
  logic [W-1:0] period_data;
`ifdef TICK_GEN_PHASE_SYNC_EN
  logic         sync_clr;
`endif
  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  tick_gen_multi #(.NUM_CH(N), .CNT_W(W), .DEFAULT_PERIOD(4)) dut (
    .i_clock      (clock),
    .i_reset_n    (reset_n),
    .i_enable     (enable),
    .i_oneshot    (oneshot),
    .i_period_wr  (period_wr),
    .i_period_sel (period_sel),
    .i_period_data(period_data),
`ifdef TICK_GEN_PHASE_SYNC_EN
    .i_sync_clr   (sync_clr),
`endif
    .o_tick       (tick),
    .o_level      (level),
    .o_done       (done)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = '0;
    oneshot = '0;
    period_wr = 1'b0;
    period_sel = '0;
    period_data = '0;
`ifdef TICK_GEN_PHASE_SYNC_EN
    sync_clr = 1'b0;
`endif
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic wr_period(input logic [1:0] sel, input logic [W-1:0] data);
    period_wr = 1'b1;
    period_sel = sel;
    period_data = data;
    cyc();
    period_wr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    cyc();
    n_total++;
    if (tick !== 3'b000) $display("FAIL reset_tick got=%b exp=000", tick); else n_pass++;
    n_total++;
    if (level !== 3'b000) $display("FAIL reset_level got=%b exp=000", level); else n_pass++;
    n_total++;
    if (done !== 3'b000) $display("FAIL reset_done got=%b exp=000", done); else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_default_period();
    logic [N-1:0] et, el;
    do_reset();
    enable = 3'b001;
    cyc();
    for (int k = 1; k <= 13; k++) begin
      cyc();
      et = (k % 4 == 0) ? 3'b001 : 3'b000;
      el = ((k / 4) % 2 == 1) ? 3'b001 : 3'b000;
      n_total++;
      if (tick !== et) $display("FAIL default_tick k=%0d got=%b exp=%b", k, tick, et); else n_pass++;
      n_total++;
      if (level !== el) $display("FAIL default_level k=%0d got=%b exp=%b", k, level, el); else n_pass++;
    end
  endtask

  task automatic test_reload();
    logic et;
    do_reset();
    wr_period(2'd1, 5);
    enable = 3'b010;
    cyc();
    for (int k = 1; k <= 17; k++) begin
      if (k == 8) begin
        period_wr = 1'b1;
        period_sel = 2'd1;
        period_data = 3;
      end
      if (k == 9) period_wr = 1'b0;
      cyc();
      et = (k == 5 || k == 10 || k == 13 || k == 16);
      n_total++;
      if (tick !== {1'b0, et, 1'b0}) $display("FAIL reload_tick k=%0d got=%b exp=0%b0", k, tick, et); else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    wr_period(2'd2, 6);
    oneshot = 3'b100;
    enable = 3'b100;
    cyc();
    for (int k = 1; k <= 10; k++) begin
      cyc();
      n_total++;
      if (tick[2] !== (k == 6)) $display("FAIL oneshot_tick k=%0d got=%b exp=%b", k, tick[2], k == 6); else n_pass++;
      n_total++;
      if (done[2] !== (k >= 6)) $display("FAIL oneshot_done k=%0d got=%b exp=%b", k, done[2], k >= 6); else n_pass++;
    end
    enable = 3'b000;
    cyc();
    n_total++;
    if (done !== 3'b000) $display("FAIL oneshot_done_clear got=%b exp=000", done); else n_pass++;
    enable = 3'b100;
    cyc();
    for (int k = 1; k <= 9; k++) begin
      cyc();
      n_total++;
      if (tick[2] !== (k == 6)) $display("FAIL oneshot_rearm_tick k=%0d got=%b exp=%b", k, tick[2], k == 6); else n_pass++;
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    wr_period(2'd0, 1);
    enable = 3'b001;
    cyc();
    for (int k = 1; k <= 6; k++) begin
      cyc();
      n_total++;
      if (tick !== 3'b001) $display("FAIL p1_tick k=%0d got=%b exp=001", k, tick); else n_pass++;
      n_total++;
      if (level[0] !== 1'(k % 2)) $display("FAIL p1_level k=%0d got=%b exp=%0d", k, level[0], k % 2); else n_pass++;
    end
    do_reset();
    wr_period(2'd0, 3);
    enable = 3'b001;
    cyc();
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) begin
        period_wr = 1'b1;
        period_sel = 2'd0;
        period_data = 0;
      end
      if (k == 6) period_wr = 1'b0;
      cyc();
      n_total++;
      if (tick[0] !== (k == 3 || k == 6)) $display("FAIL p0_stop_tick k=%0d got=%b exp=%b", k, tick[0], k == 3 || k == 6); else n_pass++;
    end
    do_reset();
    wr_period(2'd3, 2);
    enable = 3'b111;
    cyc();
    for (int k = 1; k <= 5; k++) begin
      cyc();
      n_total++;
      if (tick !== ((k == 4) ? 3'b111 : 3'b000)) $display("FAIL bad_sel_tick k=%0d got=%b exp=%b", k, tick, (k == 4) ? 3'b111 : 3'b000); else n_pass++;
    end
  endtask

  task automatic test_disable_reset();
    do_reset();
    enable = 3'b001;
    cyc();
    for (int k = 1; k <= 6; k++) cyc();
    enable = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_total++;
      if (tick !== 3'b000) $display("FAIL disable_tick k=%0d got=%b exp=000", k, tick); else n_pass++;
      n_total++;
      if (level !== 3'b001) $display("FAIL disable_level k=%0d got=%b exp=001", k, level); else n_pass++;
    end
    enable = 3'b101;
    oneshot = 3'b100;
    cyc();
    for (int k = 1; k <= 4; k++) cyc();
    n_total++;
    if (tick !== 3'b101) $display("FAIL premid_tick got=%b exp=101", tick); else n_pass++;
    n_total++;
    if (level !== 3'b100) $display("FAIL premid_level got=%b exp=100", level); else n_pass++;
    n_total++;
    if (done !== 3'b100) $display("FAIL premid_done got=%b exp=100", done); else n_pass++;
    reset_n = 1'b0;
    cyc();
    n_total++;
    if ({tick, level, done} !== 9'b0) $display("FAIL midreset_outputs got=%b exp=000000000", {tick, level, done}); else n_pass++;
    reset_n = 1'b1;
  endtask

`ifdef TICK_GEN_PHASE_SYNC_EN
  task automatic test_sync();
    do_reset();
    enable = 3'b001;
    cyc();
    cyc();
    enable = 3'b011;
    cyc();
    sync_clr = 1'b1;
    cyc();
    sync_clr = 1'b0;
    n_total++;
    if ({tick, level} !== 6'b0) $display("FAIL sync_clear got=%b exp=000000", {tick, level}); else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      n_total++;
      if (tick !== ((k % 4 == 0) ? 3'b011 : 3'b000)) $display("FAIL sync_tick k=%0d got=%b exp=%b", k, tick, (k % 4 == 0) ? 3'b011 : 3'b000); else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_period();
    test_reload();
    test_oneshot();
    test_boundaries();
    test_disable_reset();
`ifdef TICK_GEN_PHASE_SYNC_EN
    test_sync();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
